mem_ctrl: RTL and testbench
===========================

# mem_ctrl

- Single-port memory controller sitting directly upstream of the word-wide `sram` block (32-bit data, 16-bit word address, one-cycle registered read).
- Accepts byte/halfword/word load and store requests from the CPU load/store unit through a valid/ready handshake.
- Translates byte addresses to word indices and performs read-modify-write for sub-word stores.
- Returns extended load data or an error response for misaligned and out-of-range accesses.

## Interface
Parameters:
- MEM_WORDS, 16384, number of 32-bit words in the attached sram; legal word index is 0..MEM_WORDS-1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; request accepted on edge where req_valid & req_ready.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- req_signed  in  1  loads only: sign-extend sub-word data, else zero-extend.
- req_addr  in  32  byte address, little-endian lanes.
- req_wdata  in  32  store data; byte in [7:0], halfword in [15:0].
- resp_valid  out  1  one-cycle response pulse; no back-pressure.
- resp_err  out  1  valid with resp_valid; 1 = access rejected.
- resp_rdata  out  32  load result; 0 for stores and errors.
- sram_rd_en  out  1  registered read strobe to sram.
- sram_wr_en  out  1  registered write strobe to sram.
- sram_addr  out  16  word index {2'b00, req_addr[15:2]} (zero-padded).
- sram_idata  out  32  write data to sram.
- sram_odata  in  32  sram read data, valid the cycle after the edge that sampled sram_rd_en.

## Operation
- States: IDLE, READ, READ_CAP, RMW_READ, RMW_MERGE, WRITE.
- req_ready = 1 only in IDLE; all request fields are registered on acceptance.
- Error check at acceptance, in priority order:
  - size 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:2] >= MEM_WORDS.
  - Error → stay IDLE, pulse resp_valid with resp_err = 1 and rdata 0 next cycle; sram strobes never asserted.
- Load: IDLE→READ (sram_rd_en = 1)→READ_CAP (sram_rd_en = 0)→IDLE.
  - In READ_CAP, sram_odata is captured into resp_rdata.
  - Byte lane = addr[1:0], using bits [8n+7:8n]; halfword lane = addr[1], using [15:0] or [31:16].
  - Sub-word result is zero- or sign-extended per req_signed; word passes through unchanged.
- Word store: IDLE→WRITE (sram_wr_en = 1, sram_idata = wdata)→IDLE, with resp_valid.
- Sub-word store: IDLE→RMW_READ (sram_rd_en)→RMW_MERGE→WRITE→IDLE.
  - RMW_MERGE replaces only the addressed lane(s) of sram_odata with wdata low bits and registers the result into sram_idata.
- sram_rd_en and sram_wr_en are never high together; sram_addr is held stable for the whole transaction.
- Reset: state IDLE, req_ready 1 after release.
  - resp_valid, resp_err, resp_rdata, sram_rd_en, sram_wr_en, sram_addr and sram_idata all 0.
  - An in-flight transaction is dropped with no response; a partial RMW never writes.

## Timing
- Edge E0 = acceptance edge.
- Load: sram samples rd_en at E1; resp_valid high after E2 (2-cycle latency).
- Word store: sram writes at E1; resp_valid high after E1.
- Sub-word store: sram read at E1, merge at E2, write at E3; resp_valid high after E3.
- Error: resp_valid/resp_err high after E0; req_ready stays 1.
- resp_valid is asserted in the same cycle the FSM re-enters IDLE, so req_ready is 1 that cycle and back-to-back requests are accepted with no bubble.
- Load issued right after a store to the same word returns the new data (write completes at an earlier edge).

## Test plan
- Word store then load: store 0xDEADBEEF @0x100, load word @0x100.
  - Response after 1 cycle with err 0; sram_addr 0x0040.
  - Load resp_rdata 0xDEADBEEF exactly 2 cycles after acceptance.
- Byte RMW: word @0x100 = 0xDEADBEEF, store byte 0x12 @0x102.
  - Response after 3 cycles.
  - Word load returns 0xDE12BEEF.
  - Signed byte load @0x103 returns 0xFFFFFFDE; unsigned returns 0x000000DE.
- Halfword: store 0x8001 @0x106, signed half load @0x106 → 0xFFFF8001, unsigned → 0x00008001.
- Errors, each giving resp_err = 1 one cycle after acceptance with no sram strobe:
  - word @0x101;
  - half @0x103;
  - size 11;
  - word @0x00010000 with MEM_WORDS 16384.
- Back-to-back: three loads issued whenever req_ready; each accepted in the cycle its predecessor responds; responses in order.
- Reset mid-RMW: assert rst in the RMW_MERGE cycle.
  - All outputs 0 immediately; no sram_wr_en pulse; no resp_valid.
  - req_ready 1 after release.

Source files
------------

// File: rtl/mem_ctrl.sv
// Load/store front end for a word-wide, one-cycle-latency sram.
// Handles byte/halfword/word accesses, read-modify-write sub-word stores, and error responses.
module mem_ctrl #(
  parameter int unsigned MEM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [15:0] sram_addr,
  output logic [31:0] sram_idata,
  input  logic [31:0] sram_odata
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned HW = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    READ_CAP,
    RMW_READ,
    RMW_MERGE,
    WRITE
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic            rd_en_q, rd_en_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   idata_q, idata_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [1:0]      lane_q, lane_d;
  logic [HW-1:0]   wdata_q, wdata_d;
  logic            req_err_c;

  // Select the addressed lane of a fetched word and extend it to 32 bits.
  function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] word,
                                                 input logic [1:0]    size,
                                                 input logic          sgn,
                                                 input logic [1:0]    lane);
    logic [7:0]    b;
    logic [HW-1:0] h;
    logic [DW-1:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the store data onto the addressed lane(s) of the old word.
  function automatic logic [DW-1:0] store_merge(input logic [DW-1:0] word,
                                                input logic [HW-1:0] wd,
                                                input logic [1:0]    size,
                                                input logic [1:0]    lane);
    logic [DW-1:0] r;
    r = word;
    if (size == SZ_HALF) begin
      if (lane[1]) r[31:16] = wd;
      else         r[15:0]  = wd;
    end else begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end
    return r;
  endfunction

  assign req_err_c = (req_size == SZ_RSVD)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                   | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      idata_q      <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      lane_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      idata_q      <= idata_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    addr_d       = addr_q;
    idata_d      = idata_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err_c) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            size_d  = req_size;
            sgn_d   = req_signed;
            lane_d  = req_addr[1:0];
            wdata_d = req_wdata[HW-1:0];
            addr_d  = {2'b00, req_addr[15:2]};
            if (!req_wr) begin
              rd_en_d = 1'b1;
              state_d = READ;
            end else if (req_size == SZ_WORD) begin
              wr_en_d = 1'b1;
              idata_d = req_wdata;
              state_d = WRITE;
            end else begin
              rd_en_d = 1'b1;
              state_d = RMW_READ;
            end
          end
        end
      end
      READ:      state_d = READ_CAP;
      READ_CAP: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_extract(sram_odata, size_q, sgn_q, lane_q);
        state_d      = IDLE;
      end
      RMW_READ:  state_d = RMW_MERGE;
      RMW_MERGE: begin
        idata_d = store_merge(sram_odata, wdata_q, size_q, lane_q);
        wr_en_d = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default:   state_d = IDLE;
    endcase

    // Ready tracks the state being entered so back-to-back requests see no bubble.
    ready_d = (state_d == IDLE);
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign sram_rd_en = rd_en_q;
  assign sram_wr_en = wr_en_q;
  assign sram_addr  = addr_q;
  assign sram_idata = idata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed plus randomized bench for mem_ctrl against a byte-addressed reference memory.
module tb_mem_ctrl;

  localparam int unsigned MEM_WORDS = 16384;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [15:0] sram_addr;
  logic [31:0] sram_idata;
  logic [31:0] sram_odata;

  int n_asserts = 0;
  int n_fails   = 0;

  bit [31:0] sram_mem [0:65535];
  bit [7:0]  mdl      [0:65535];

  mem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .sram_rd_en (sram_rd_en),
    .sram_wr_en (sram_wr_en),
    .sram_addr  (sram_addr),
    .sram_idata (sram_idata),
    .sram_odata (sram_odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-wide sram with one-cycle registered read.
  always @(posedge clk) begin
    if (sram_wr_en) sram_mem[sram_addr] <= sram_idata;
    if (sram_rd_en) sram_odata <= sram_mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_err"},   32'(resp_err),   32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,      32'd0);
    check({tag, "_rd_en"},      32'(sram_rd_en), 32'd0);
    check({tag, "_wr_en"},      32'(sram_wr_en), 32'd0);
    check({tag, "_sram_addr"},  32'(sram_addr),  32'd0);
    check({tag, "_sram_idata"}, sram_idata,      32'd0);
  endtask

  // One request end to end; expectations come from the byte-level model.
  task automatic do_req(input string tag, input bit wr, input bit [1:0] size, input bit sgn,
                        input bit [31:0] addr, input bit [31:0] wdata, output logic [31:0] got);
    int        nbytes;
    bit        exp_err;
    int        exp_lat;
    bit [31:0] exp_rdata;
    int        lat;
    bit        seen;
    int        rd_cnt;
    int        wr_cnt;
    int        waits;

    nbytes    = 1 << size;
    exp_err   = (size == 2'b11) || ((addr % nbytes) != 0) || ((addr >> 2) >= MEM_WORDS);
    exp_lat   = exp_err ? 0 : (!wr ? 2 : (size == 2'b10 ? 1 : 3));
    exp_rdata = '0;
    if (!exp_err && !wr) begin
      for (int i = 0; i < nbytes; i++) exp_rdata[8*i +: 8] = mdl[addr + i];
      if (sgn && nbytes < 4 && exp_rdata[8*nbytes-1])
        for (int i = 8*nbytes; i < 32; i++) exp_rdata[i] = 1'b1;
    end

    @(negedge clk);
    req_valid  = 1'b1;
    req_wr     = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    check({tag, "_ready_at_issue"}, 32'(req_ready), 32'd1);
    waits = 0;
    while (!req_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end

    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0; seen = 1'b0; rd_cnt = 0; wr_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (sram_rd_en) rd_cnt++;
      if (sram_wr_en) wr_cnt++;
      if (sram_rd_en || sram_wr_en) begin
        check({tag, "_sram_addr"}, 32'(sram_addr), 32'(addr[17:2]));
        check({tag, "_strobe_excl"}, 32'(sram_rd_en & sram_wr_en), 32'd0);
      end
      if (resp_valid) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      @(posedge clk);
      #1;
    end

    got = resp_rdata;
    check({tag, "_resp_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_resp_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_rd_strobes"}, 32'(rd_cnt), (!exp_err && (!wr || size != 2'b10)) ? 32'd1 : 32'd0);
    check({tag, "_wr_strobes"}, 32'(wr_cnt), (!exp_err && wr) ? 32'd1 : 32'd0);
    check({tag, "_ready_at_resp"}, 32'(req_ready), 32'd1);

    if (!exp_err && wr)
      for (int i = 0; i < nbytes; i++) mdl[addr + i] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [31:0] got;
    bit   [31:0] addr;
    int          r;

    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr  = '0;   req_wdata = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("reset_ready", 32'(req_ready), 32'd1);

    do_req("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, got);
    do_req("ld_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, got);
    check("ld_word_const", got, 32'hDEADBEEF);

    do_req("st_byte", 1'b1, 2'b00, 1'b0, 32'h102, 32'hFFFFFF12, got);
    do_req("ld_after_byte", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, got);
    check("rmw_word_const", got, 32'hDE12BEEF);
    do_req("ld_sbyte", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, got);
    check("ld_sbyte_const", got, 32'hFFFFFFDE);
    do_req("ld_ubyte", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, got);
    check("ld_ubyte_const", got, 32'h000000DE);

    do_req("st_half", 1'b1, 2'b01, 1'b0, 32'h106, 32'h12348001, got);
    do_req("ld_shalf", 1'b0, 2'b01, 1'b1, 32'h106, 32'h0, got);
    check("ld_shalf_const", got, 32'hFFFF8001);
    do_req("ld_uhalf", 1'b0, 2'b01, 1'b0, 32'h106, 32'h0, got);
    check("ld_uhalf_const", got, 32'h00008001);

    do_req("err_word_mis", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, got);
    do_req("err_half_mis", 1'b1, 2'b01, 1'b0, 32'h103, 32'h5555, got);
    do_req("err_size11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, got);
    do_req("err_range", 1'b1, 2'b10, 1'b0, 32'h00010000, 32'h1, got);
    do_req("last_word_st", 1'b1, 2'b10, 1'b0, 32'h0000FFFC, 32'hCAFEF00D, got);
    do_req("last_word_ld", 1'b0, 2'b10, 1'b0, 32'h0000FFFC, 32'h0, got);
    check("last_word_const", got, 32'hCAFEF00D);

    do_req("b2b_0", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, got);
    do_req("b2b_1", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, got);
    do_req("b2b_2", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, got);
    check("b2b_2_const", got, 32'h00000012);

    // Reset asserted while the controller sits in the merge cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h104; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_outputs_zero("midrmw");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("midrmw_hold_wr", 32'(sram_wr_en), 32'd0);
      check("midrmw_hold_resp", 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("midrmw_post_wr", 32'(sram_wr_en), 32'd0);
      check("midrmw_post_resp", 32'(resp_valid), 32'd0);
    end
    check("midrmw_ready", 32'(req_ready), 32'd1);
    do_req("midrmw_ld", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, got);
    check("midrmw_ld_const", got, 32'h80010000);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      addr = 32'h0001_0000 + 32'($urandom_range(0, 255));
      else if (r == 1) addr = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
      else             addr = 32'h0000_0100 + 32'($urandom_range(0, 63));
      do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), addr, $urandom, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
